kb_scan_ctrl: RTL and testbench
===============================

Name: kb_scan_ctrl

Overview:
Scancode-sequencing controller for the PS/2 keyboard receive path. It consumes the validated byte stream from the PS/2 receiver and strips set-2 prefixes (E0, F0, E1 pause sequence) and link-control bytes. It tracks modifier state (shift, ctrl, alt, caps lock) and hands one complete key event at a time to the downstream character/display logic over a valid/ready handshake. It replaces per-modifier trackers with a single sequencer.

Parameters:
PAUSE_SKIP, 7, number of bytes consumed after an E1 prefix before the pause event is emitted (range 1..15).

Ports:
clk  input  1  system clock; all state changes on rising edge.
i_sclr  input  1  synchronous active-high reset.
i_byte_en  input  1  one-cycle strobe; i_byte valid this cycle.
i_byte  input  8  received scancode byte.
i_ev_ready  input  1  downstream accepts event this cycle.
o_ev_valid  output  1  event register holds an unconsumed event.
o_ev_code  output  8  final scancode byte of event (E1 for pause).
o_ev_brk  output  1  1 = break (release), 0 = make.
o_ev_ext  output  1  event was E0-prefixed.
o_mods  output  4  {caps_lock, alt, ctrl, shift}, live modifier state.
o_overflow  output  1  sticky: an event was dropped.

Behaviour:
- Reset (i_sclr=1 at an edge) overrides everything. State=IDLE, skip counter=0, all internal modifier bits=0, o_ev_valid=0, o_ev_code=0, o_ev_brk=0, o_ev_ext=0, o_mods=0, o_overflow=0. A reset mid-prefix or mid-pause discards the partial sequence.
- The FSM advances only on cycles with i_byte_en=1.
- States:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (counter loads PAUSE_SKIP); other code->emit make, ext=0.
  - EXT: F0->EXTBRK; other code->emit make, ext=1; ->IDLE.
  - BRK: code->emit break, ext=0; ->IDLE.
  - EXTBRK: code->emit break, ext=1; ->IDLE.
  - PAUSE: decrement on each byte; the byte that takes the counter 1->0 emits make, code=E1, ext=0; ->IDLE. Bytes are not decoded in PAUSE.
- Control bytes 00, AA, EE, FA, FC, FD, FE, FF received in any state except PAUSE:
  - produce no event and no modifier change;
  - return the FSM to IDLE.
- A prefix byte received in the wrong state (E0 in EXT/BRK/EXTBRK, or F0 in BRK/EXTBRK) restarts decoding as if received in IDLE.
- Modifier tracking updates on the same edge as the emit. Make sets the bit, break clears it. Tracking is independent of the handshake, so dropped events still update modifiers. Internal bits:
  - lshift: 12, ext=0.
  - rshift: 59, ext=0.
  - lctrl: 14, ext=0.
  - rctrl: 14, ext=1.
  - lalt: 11, ext=0.
  - ralt: 11, ext=1.
  - E0 12 (print-screen fake shift) does not affect shift.
- o_mods combines the internal bits:
  - shift = lshift|rshift.
  - ctrl = lctrl|rctrl.
  - alt = lalt|ralt.
- Caps lock (58, ext=0):
  - The first make toggles caps_lock and sets internal caps_held.
  - Repeated makes while caps_held=1 do not toggle.
  - Break clears caps_held.
- Event register and handshake:
  - Emit with o_ev_valid=0, or with o_ev_valid=1 and i_ev_ready=1 in the same cycle: load the fields and set o_ev_valid=1 on the next edge. Latency is 1 cycle from the final byte's i_byte_en.
  - Emit with o_ev_valid=1 and i_ev_ready=0: the new event is dropped, the held event is unchanged, and o_overflow is set and stays set until reset.
  - No emit and i_ev_ready=1: o_ev_valid clears next edge.
  - Fields hold their values while o_ev_valid=0.
  - Every emitted event is offered downstream, including modifier keys.

Optional Feature:
KB_TYPEMATIC_FILTER_EN.
- Defined:
  - A 9-bit register {ext, code} records the last emitted make plus a flag last_held.
  - A make matching the register while last_held=1 is suppressed: no event and no overflow.
  - Modifier and caps processing still occurs.
  - A break matching the register clears last_held.
  - Reset clears the register and last_held.
- Undefined: every make is emitted. Caps toggle suppression on repeats stays active in both builds.

Test Plan:
- Bytes 1C, F0, 1C with i_ev_ready=1 -> two events: {code=1C, brk=0, ext=0}, then {1C, brk=1, ext=0}. o_ev_valid rises the cycle after each final byte.
- Bytes 12, 1C, F0, 12 -> o_mods[0]=1 after the first byte. The 1C event is seen with o_mods=4'b0001. o_mods returns to 0 after F0 12.
- Bytes E0 14, then E0 F0 14 -> events {14, brk=0, ext=1} and {14, brk=1, ext=1}. o_mods[1] goes 1 then 0. Bytes E0 12 leave o_mods[0]=0.
- Bytes 58, 58, 58, F0 58, 58 -> caps_lock goes 1, stays 1 through the repeats, then 0 after the second press. With KB_TYPEMATIC_FILTER_EN, only 2 make events for 58 are emitted (3 breaks/makes total instead of 5).
- Bytes E1 14 77 E1 F0 14 F0 77 (PAUSE_SKIP=7) -> exactly one event {E1, brk=0, ext=0} after the 8th byte. An AA inside the pause sequence is counted, not discarded.
- i_ev_ready held 0; bytes 1C, 32 -> 1C stays held, 32 dropped, o_overflow=1. Assert ready for 1 cycle -> o_ev_valid=0. o_overflow stays 1 until i_sclr. i_sclr after E0 -> the next 1C gives ext=0.

Source files
------------

// File: rtl/kb_scan_ctrl.sv
// Purpose: PS/2 set-2 scancode sequencer; strips E0/F0/E1 prefixes and link-control bytes, tracks modifiers, emits one key event at a time.
// Latency: event visible on o_ev_valid 1 cycle after the final byte's i_byte_en strobe.
// Backpressure: one-entry event register; an emit while an event is still held and not taken is dropped and sets sticky o_overflow.
// Optional build macro: KB_TYPEMATIC_FILTER_EN suppresses repeated makes of the key that is still held.
module kb_scan_ctrl #(
   parameter int PAUSE_SKIP = 7
) (
   input  logic       clk,
   input  logic       i_sclr,
   input  logic       i_byte_en,
   input  logic [7:0] i_byte,
   input  logic       i_ev_ready,
   output logic       o_ev_valid,
   output logic [7:0] o_ev_code,
   output logic       o_ev_brk,
   output logic       o_ev_ext,
   output logic [3:0] o_mods,
   output logic       o_overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXTBRK,
      S_PAUSE
   } state_t;

   localparam logic [3:0] SKIP_LD = 4'(PAUSE_SKIP);

   state_t     state, state_nxt;
   logic [3:0] skip_cnt, skip_cnt_nxt;

   // decoded event from the current byte, before handshake and filtering
   logic       emit;
   logic [7:0] em_code;
   logic       em_brk;
   logic       em_ext;
   logic       suppress;
   logic       emit_ok;

   logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
   logic       caps_lock, caps_held;
   logic       is_ctrl_byte;

   // link-control bytes never carry key information
   always_comb begin
      is_ctrl_byte = 1'b0;
      case (i_byte)
         8'h00, 8'hAA, 8'hEE, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl_byte = 1'b1;
         default:                    is_ctrl_byte = 1'b0;
      endcase
   end

   // state register and pause skip counter
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         state    <= S_IDLE;
         skip_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_cnt_nxt;
      end
   end

   // next-state decode; prefixes seen mid-sequence restart decoding as if from IDLE
   always_comb begin
      state_nxt    = state;
      skip_cnt_nxt = skip_cnt;
      emit         = 1'b0;
      em_code      = i_byte;
      em_brk       = 1'b0;
      em_ext       = 1'b0;
      if (i_byte_en) begin
         if (state == S_PAUSE) begin
            // pause bytes are only counted, never decoded
            if (skip_cnt <= 4'd1) begin
               emit         = 1'b1;
               em_code      = 8'hE1;
               state_nxt    = S_IDLE;
               skip_cnt_nxt = 4'd0;
            end else begin
               skip_cnt_nxt = skip_cnt - 4'd1;
            end
         end else if (is_ctrl_byte) begin
            state_nxt = S_IDLE;
         end else if (i_byte == 8'hE0) begin
            state_nxt = S_EXT;
         end else if (i_byte == 8'hF0) begin
            state_nxt = (state == S_EXT) ? S_EXTBRK : S_BRK;
         end else if ((i_byte == 8'hE1) && (state == S_IDLE)) begin
            state_nxt    = S_PAUSE;
            skip_cnt_nxt = SKIP_LD;
         end else begin
            emit      = 1'b1;
            em_brk    = (state == S_BRK) || (state == S_EXTBRK);
            em_ext    = (state == S_EXT) || (state == S_EXTBRK);
            state_nxt = S_IDLE;
         end
      end
   end

`ifdef KB_TYPEMATIC_FILTER_EN
   logic [8:0] last_key;
   logic       last_held;
   logic       last_match;

   assign last_match = (last_key == {em_ext, em_code});
   assign suppress   = emit && !em_brk && last_held && last_match;

   // remember the last make so auto-repeat of a held key is swallowed
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         last_key  <= 9'd0;
         last_held <= 1'b0;
      end else if (emit) begin
         if (!em_brk && !suppress) begin
            last_key  <= {em_ext, em_code};
            last_held <= 1'b1;
         end else if (em_brk && last_match) begin
            last_held <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign emit_ok = emit && !suppress;

   // modifier tracking follows every decoded key, even ones dropped or filtered
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         lctrl     <= 1'b0;
         rctrl     <= 1'b0;
         lalt      <= 1'b0;
         ralt      <= 1'b0;
         caps_lock <= 1'b0;
         caps_held <= 1'b0;
      end else if (emit) begin
         // E0 12 is the print-screen fake shift and is deliberately ignored
         if (!em_ext) begin
            case (em_code)
               8'h12: lshift <= !em_brk;
               8'h59: rshift <= !em_brk;
               8'h14: lctrl  <= !em_brk;
               8'h11: lalt   <= !em_brk;
               8'h58: begin
                  if (em_brk) begin
                     caps_held <= 1'b0;
                  end else if (!caps_held) begin
                     caps_lock <= !caps_lock;
                     caps_held <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else begin
            case (em_code)
               8'h14:   rctrl <= !em_brk;
               8'h11:   ralt  <= !em_brk;
               default: ;
            endcase
         end
      end
   end

   assign o_mods = {caps_lock, lalt | ralt, lctrl | rctrl, lshift | rshift};

   // single-entry event register with sticky drop flag
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         o_ev_valid <= 1'b0;
         o_ev_code  <= 8'd0;
         o_ev_brk   <= 1'b0;
         o_ev_ext   <= 1'b0;
         o_overflow <= 1'b0;
      end else if (emit_ok) begin
         if (!o_ev_valid || i_ev_ready) begin
            o_ev_valid <= 1'b1;
            o_ev_code  <= em_code;
            o_ev_brk   <= em_brk;
            o_ev_ext   <= em_ext;
         end else begin
            o_overflow <= 1'b1;
         end
      end else if (i_ev_ready) begin
         o_ev_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kb_scan_ctrl.sv
module tb_kb_scan_ctrl;

   logic       clk;
   logic       i_sclr;
   logic       i_byte_en;
   logic [7:0] i_byte;
   logic       i_ev_ready;
   logic       o_ev_valid;
   logic [7:0] o_ev_code;
   logic       o_ev_brk;
   logic       o_ev_ext;
   logic [3:0] o_mods;
   logic       o_overflow;

   int checks = 0;
   int errors = 0;
   int ev_cnt = 0;
   int ev58_cnt = 0;

   kb_scan_ctrl #(.PAUSE_SKIP(7)) dut (
      .clk        (clk),
      .i_sclr     (i_sclr),
      .i_byte_en  (i_byte_en),
      .i_byte     (i_byte),
      .i_ev_ready (i_ev_ready),
      .o_ev_valid (o_ev_valid),
      .o_ev_code  (o_ev_code),
      .o_ev_brk   (o_ev_brk),
      .o_ev_ext   (o_ev_ext),
      .o_mods     (o_mods),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // count handshakes seen by the consumer
   always @(posedge clk) begin
      if (!i_sclr && o_ev_valid && i_ev_ready) begin
         ev_cnt <= ev_cnt + 1;
         if (o_ev_code == 8'h58) ev58_cnt <= ev58_cnt + 1;
      end
   end

   // one byte strobe, then one idle cycle; returns on a falling edge
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      i_byte_en = 1'b1;
      i_byte    = b;
      @(negedge clk);
      i_byte_en = 1'b0;
      i_byte    = 8'h00;
   endtask

   task automatic test_reset();
      i_sclr = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods, o_overflow} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got v=%b code=%h brk=%b ext=%b mods=%b ovf=%b, expected all zero",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods, o_overflow);
      end
      i_sclr = 1'b0;
      @(negedge clk);
      checks++;
      if (o_ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_valid: got %b expected 0", o_ev_valid);
      end
   endtask

   task automatic test_make_break();
      send_byte(8'h1C);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL make_1C: got v=%b code=%h brk=%b ext=%b expected v=1 code=1c brk=0 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      send_byte(8'hF0);
      checks++;
      if (o_ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL prefix_no_event: got v=%b expected 0", o_ev_valid);
      end
      send_byte(8'h1C);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h1C, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL break_1C: got v=%b code=%h brk=%b ext=%b expected v=1 code=1c brk=1 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
   endtask

   task automatic test_shift();
      send_byte(8'h12);
      checks++;
      if (o_mods !== 4'b0001) begin
         errors++;
         $display("FAIL lshift_make_mods: got %b expected 0001", o_mods);
      end
      send_byte(8'h1C);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_mods} !== {1'b1, 8'h1C, 1'b0, 4'b0001}) begin
         errors++;
         $display("FAIL shifted_1C: got v=%b code=%h brk=%b mods=%b expected v=1 code=1c brk=0 mods=0001",
                  o_ev_valid, o_ev_code, o_ev_brk, o_mods);
      end
      send_byte(8'hF0);
      send_byte(8'h12);
      checks++;
      if (o_mods !== 4'b0000) begin
         errors++;
         $display("FAIL lshift_break_mods: got %b expected 0000", o_mods);
      end
      send_byte(8'h59);
      checks++;
      if (o_mods !== 4'b0001) begin
         errors++;
         $display("FAIL rshift_make_mods: got %b expected 0001", o_mods);
      end
      send_byte(8'hF0);
      send_byte(8'h59);
      send_byte(8'h11);
      checks++;
      if (o_mods !== 4'b0100) begin
         errors++;
         $display("FAIL lalt_make_mods: got %b expected 0100", o_mods);
      end
      send_byte(8'hF0);
      send_byte(8'h11);
      checks++;
      if (o_mods !== 4'b0000) begin
         errors++;
         $display("FAIL lalt_break_mods: got %b expected 0000", o_mods);
      end
   endtask

   task automatic test_ext_ctrl();
      send_byte(8'hE0);
      send_byte(8'h14);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods} !== {1'b1, 8'h14, 1'b0, 1'b1, 4'b0010}) begin
         errors++;
         $display("FAIL rctrl_make: got v=%b code=%h brk=%b ext=%b mods=%b expected v=1 code=14 brk=0 ext=1 mods=0010",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h14);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods} !== {1'b1, 8'h14, 1'b1, 1'b1, 4'b0000}) begin
         errors++;
         $display("FAIL rctrl_break: got v=%b code=%h brk=%b ext=%b mods=%b expected v=1 code=14 brk=1 ext=1 mods=0000",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext, o_mods);
      end
      send_byte(8'hE0);
      send_byte(8'h12);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_ext, o_mods} !== {1'b1, 8'h12, 1'b1, 4'b0000}) begin
         errors++;
         $display("FAIL fake_shift: got v=%b code=%h ext=%b mods=%b expected v=1 code=12 ext=1 mods=0000",
                  o_ev_valid, o_ev_code, o_ev_ext, o_mods);
      end
      send_byte(8'hE0);
      send_byte(8'h11);
      checks++;
      if (o_mods !== 4'b0100) begin
         errors++;
         $display("FAIL ralt_make_mods: got %b expected 0100", o_mods);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h11);
   endtask

   task automatic test_caps();
      int base;
      base = ev58_cnt;
      send_byte(8'h58);
      checks++;
      if (o_mods !== 4'b1000) begin
         errors++;
         $display("FAIL caps_first_press: got mods=%b expected 1000", o_mods);
      end
      send_byte(8'h58);
      send_byte(8'h58);
      checks++;
      if (o_mods !== 4'b1000) begin
         errors++;
         $display("FAIL caps_repeat_hold: got mods=%b expected 1000", o_mods);
      end
      send_byte(8'hF0);
      send_byte(8'h58);
      checks++;
      if (o_mods !== 4'b1000) begin
         errors++;
         $display("FAIL caps_release: got mods=%b expected 1000", o_mods);
      end
      send_byte(8'h58);
      checks++;
      if (o_mods !== 4'b0000) begin
         errors++;
         $display("FAIL caps_second_press: got mods=%b expected 0000", o_mods);
      end
      @(negedge clk);
      checks++;
`ifdef KB_TYPEMATIC_FILTER_EN
      if (ev58_cnt - base !== 3) begin
         errors++;
         $display("FAIL caps_event_count: got %0d expected 3", ev58_cnt - base);
      end
`else
      if (ev58_cnt - base !== 5) begin
         errors++;
         $display("FAIL caps_event_count: got %0d expected 5", ev58_cnt - base);
      end
`endif
   endtask

   task automatic test_pause(input logic [7:0] third);
      logic [7:0] seq [8];
      int base;
      seq = '{8'hE1, 8'h14, third, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      base = ev_cnt;
      for (int i = 0; i < 7; i++) send_byte(seq[i]);
      checks++;
      if ((o_ev_valid !== 1'b0) || (ev_cnt !== base) || (o_mods !== 4'b0000)) begin
         errors++;
         $display("FAIL pause_early_%h: got v=%b events=%0d mods=%b expected v=0 events=0 mods=0000",
                  third, o_ev_valid, ev_cnt - base, o_mods);
      end
      send_byte(seq[7]);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'hE1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL pause_event_%h: got v=%b code=%h brk=%b ext=%b expected v=1 code=e1 brk=0 ext=0",
                  third, o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      @(negedge clk);
      checks++;
      if (ev_cnt - base !== 1) begin
         errors++;
         $display("FAIL pause_count_%h: got %0d events expected 1", third, ev_cnt - base);
      end
   endtask

   task automatic test_control_and_restart();
      send_byte(8'hE0);
      send_byte(8'hAA);
      send_byte(8'h1E);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h1E, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ctrl_after_e0: got v=%b code=%h brk=%b ext=%b expected v=1 code=1e brk=0 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      send_byte(8'hF0);
      send_byte(8'hFA);
      send_byte(8'h1D);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h1D, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ctrl_after_f0: got v=%b code=%h brk=%b ext=%b expected v=1 code=1d brk=0 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      send_byte(8'hE0);
      send_byte(8'hE0);
      send_byte(8'h2A);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h2A, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL e0_e0_restart: got v=%b code=%h brk=%b ext=%b expected v=1 code=2a brk=0 ext=1",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      send_byte(8'hF0);
      send_byte(8'hF0);
      send_byte(8'h2A);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h2A, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL f0_f0_restart: got v=%b code=%h brk=%b ext=%b expected v=1 code=2a brk=1 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'hE0);
      send_byte(8'h2B);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h2B, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL extbrk_e0_restart: got v=%b code=%h brk=%b ext=%b expected v=1 code=2b brk=0 ext=1",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
   endtask

   task automatic test_overflow();
      @(negedge clk);
      i_ev_ready = 1'b0;
      send_byte(8'h1C);
      send_byte(8'h32);
      checks++;
      if ({o_ev_valid, o_ev_code, o_overflow} !== {1'b1, 8'h1C, 1'b1}) begin
         errors++;
         $display("FAIL overflow_hold: got v=%b code=%h ovf=%b expected v=1 code=1c ovf=1",
                  o_ev_valid, o_ev_code, o_overflow);
      end
      i_ev_ready = 1'b1;
      @(negedge clk);
      i_ev_ready = 1'b0;
      checks++;
      if ({o_ev_valid, o_overflow} !== 2'b01) begin
         errors++;
         $display("FAIL overflow_drain: got v=%b ovf=%b expected v=0 ovf=1", o_ev_valid, o_overflow);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({o_ev_valid, o_ev_code, o_overflow} !== {1'b0, 8'h1C, 1'b1}) begin
         errors++;
         $display("FAIL overflow_sticky: got v=%b code=%h ovf=%b expected v=0 code=1c ovf=1",
                  o_ev_valid, o_ev_code, o_overflow);
      end
      send_byte(8'hE0);
      i_sclr = 1'b1;
      @(negedge clk);
      i_sclr = 1'b0;
      i_ev_ready = 1'b1;
      checks++;
      if ({o_overflow, o_ev_code} !== 9'h000) begin
         errors++;
         $display("FAIL overflow_cleared: got ovf=%b code=%h expected ovf=0 code=00", o_overflow, o_ev_code);
      end
      send_byte(8'h1C);
      checks++;
      if ({o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_prefix: got v=%b code=%h brk=%b ext=%b expected v=1 code=1c brk=0 ext=0",
                  o_ev_valid, o_ev_code, o_ev_brk, o_ev_ext);
      end
   endtask

   initial begin
      i_sclr     = 1'b1;
      i_byte_en  = 1'b0;
      i_byte     = 8'h00;
      i_ev_ready = 1'b1;
      test_reset();
      test_make_break();
      test_shift();
      test_ext_ctrl();
      test_caps();
      test_pause(8'h77);
      test_pause(8'hAA);
      test_control_and_restart();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
